// File: rtl/pc_gen_ras.sv
// Fetch-stage program counter with five next-PC sources and a circular
// return-address stack that overwrites its oldest entry on overflow.
module pc_gen_ras #(
  parameter int              XLEN      = 32,
  parameter int              PC_STEP   = 1,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_write,
  input  logic [1:0]                   pc_sel,
  input  logic [XLEN-1:0]              alu_out,
  input  logic [XLEN-1:0]              jump_pc,
  input  logic                         is_call,
  input  logic                         trap_req,
  input  logic [XLEN-1:0]              trap_vec,
  output logic [XLEN-1:0]              pc_out,
  output logic [XLEN-1:0]              pc_curr_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [PW-1:0]   PONE = PW'(1);
  localparam logic [CW-1:0]   CONE = CW'(1);
  localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   push_idx;
  logic            has_entry;

  // Next-PC selection and stack update; trap beats stall, stall freezes everything.
  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ras_d     = ras_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    seq_pc    = pc_q + STEP;
    push_idx  = top_q + PONE;
    has_entry = (cnt_q != {CW{1'b0}});
    if (trap_req) begin
      pc_d = trap_vec;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else begin
      case (pc_sel)
        2'd0: pc_d = seq_pc;
        2'd1: pc_d = alu_out;
        2'd2: pc_d = jump_pc;
        2'd3: begin
          if (has_entry) begin
            pc_d = ras_q[top_q];
          end else begin
            pc_d  = jump_pc;
            unf_d = 1'b1;
          end
        end
        default: pc_d = seq_pc;
      endcase
      // A return that also calls replaces the top entry instead of pop+push.
      if ((pc_sel == 2'd3) && has_entry) begin
        if (is_call) begin
          ras_d[top_q] = seq_pc;
        end else begin
          top_d = top_q - PONE;
          cnt_d = cnt_q - CONE;
        end
      end else if (is_call && (pc_sel != 2'd0)) begin
        ras_d[push_idx] = seq_pc;
        top_d           = push_idx;
        if (cnt_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end else begin
        top_d = top_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      top_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ras_q <= ras_d;
    end
  end

  assign pc_out        = (pc_write || trap_req) ? pc_q : {XLEN{1'b0}};
  assign pc_curr_o     = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic [31:0] alu_out, jump_pc, trap_vec;
  logic        is_call, trap_req;
  logic [31:0] pc_out, pc_curr_o;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  pc_gen_ras #(.XLEN(32), .PC_STEP(1), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_sel(pc_sel),
    .alu_out(alu_out), .jump_pc(jump_pc), .is_call(is_call),
    .trap_req(trap_req), .trap_vec(trap_vec), .pc_out(pc_out),
    .pc_curr_o(pc_curr_o), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_out;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected response.
  task automatic drive(input logic w, input logic [1:0] sel, input logic call,
                       input logic trap, input logic [31:0] alu,
                       input logic [31:0] jpc, input logic [31:0] tvec);
    exp_t        e;
    logic [31:0] nxt;
    logic [31:0] tgt;
    @(negedge clk);
    pc_write = w; pc_sel = sel; is_call = call; trap_req = trap;
    alu_out = alu; jump_pc = jpc; trap_vec = tvec;
    e.pc_out = (w || trap) ? m_pc : 32'h0;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (trap) begin
      m_pc = tvec;
    end else if (w) begin
      nxt = m_pc + 32'd1;
      tgt = nxt;
      case (sel)
        2'd0: tgt = nxt;
        2'd1: tgt = alu;
        2'd2: tgt = jpc;
        default: begin
          if (m_ras.size() > 0) tgt = m_ras[m_ras.size()-1];
          else begin tgt = jpc; e.unf = 1'b1; end
        end
      endcase
      if (sel == 2'd3 && m_ras.size() > 0) begin
        if (call) m_ras[m_ras.size()-1] = nxt;
        else void'(m_ras.pop_back());
      end else if (call && sel != 2'd0) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          e.ovf = 1'b1;
        end
        m_ras.push_back(nxt);
      end
      m_pc = tgt;
    end
    e.pc  = m_pc;
    e.cnt = 3'(m_ras.size());
    sbq.push_back(e);
  endtask

  task automatic seq_step();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: pc_out mid-cycle, registered state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq[0];
        check("pc_out", pc_out, e.pc_out);
        @(posedge clk);
        #1;
        check("pc_curr_o", pc_curr_o, e.pc);
        check("ras_count", {29'h0, ras_count}, {29'h0, e.cnt});
        check("ras_overflow", {31'h0, ras_overflow}, {31'h0, e.ovf});
        check("ras_underflow", {31'h0, ras_underflow}, {31'h0, e.unf});
        void'(sbq.pop_front());
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, pc_curr_o, 32'h0);
    check({tag, "_cnt"}, {29'h0, ras_count}, 32'h0);
    check({tag, "_ovf"}, {31'h0, ras_overflow}, 32'h0);
    check({tag, "_unf"}, {31'h0, ras_underflow}, 32'h0);
    check({tag, "_pc_out"}, pc_out, 32'h0);
  endtask

  initial begin
    logic [1:0] rsel;
    rst_n = 1'b0; pc_write = 1'b0; pc_sel = 2'd0; is_call = 1'b0; trap_req = 1'b0;
    alu_out = 32'h0; jump_pc = 32'h0; trap_vec = 32'h0;
    m_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch 1,2,3 then on to 5.
    repeat (5) seq_step();
    // Call to 0x40 from 5, then return to 6.
    drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // Five nested calls from 0x10..0x50 overflow a 4-deep stack.
    drive(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0);
    for (int i = 2; i <= 6; i++)
      drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 32'(i * 16), 32'h0);
    repeat (4) drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'hdead, 32'h0);
    // Return with empty stack falls back to jump_pc and pulses underflow once.
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h99, 32'h0);
    seq_step();
    // Stall ignores branch; trap during stall still redirects.
    drive(1'b0, 2'd1, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0);
    drive(1'b0, 2'd1, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0);
    drive(1'b0, 2'd3, 1'b1, 1'b1, 32'h77, 32'h0, 32'h100);
    // Call from 7 pushes 8; pop+push at 0x20 returns 8 and leaves 0x21 on top.
    drive(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h7, 32'h0);
    drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0);
    drive(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // Pop+push on empty stack: underflow plus a normal push.
    drive(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 32'h55, 32'h0);
    // Sequential increment wraps at all-ones.
    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'hffff_ffff, 32'h0, 32'h0);
    seq_step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rsel = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 7) != 0), rsel, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0), $urandom, $urandom, $urandom);
    end

    // Asynchronous reset in the middle of a cycle with stack contents live.
    drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0);
    idle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    m_pc = 32'h0;
    m_ras.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) seq_step();
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h123, 32'h0);
    idle();

    for (int t = 0; t < 20 && sbq.size() > 0; t++) @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
